// File: rtl/vt100_term_ctrl_if.sv
// Byte-stream input and screen-buffer write bus of the VT100 write-side controller.
interface vt100_term_ctrl_if;
  logic [7:0]  i_char;
  logic        i_valid;
  logic        o_ready;
  logic        o_wr;
  logic [10:0] o_wr_addr;
  logic [7:0]  o_wr_data;

  modport master (output i_char, i_valid, input o_ready, o_wr, o_wr_addr, o_wr_data);
  modport slave  (input i_char, i_valid, output o_ready, o_wr, o_wr_addr, o_wr_data);
endinterface

// File: rtl/vt100_term_ctrl.sv
// VT100 screen-buffer write controller: cursor tracking, control codes, auto-wrap,
// circular-row-base hardware scroll and line/screen clearing.
module vt100_term_ctrl #(
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 24,
  parameter logic [7:0]  FILL_CHAR      = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  vt100_term_ctrl_if.slave   bus,
  output logic [4:0]         o_row_base,
  output logic [6:0]         o_cur_x,
  output logic [4:0]         o_cur_y
);

  localparam int unsigned TOTAL     = COLS * ROWS;
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [10:0] LAST_CELL = 11'(TOTAL - 1);
  localparam logic [10:0] LINE_END  = 11'(COLS - 1);
  localparam logic [10:0] COLS_W    = 11'(COLS);
  localparam logic [5:0]  ROWS_W    = 6'(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_CLR_ALL  = 2'd2
  } state_e;

  state_e      state_r, state_nx_s;
  logic        wr_r, wr_nx_s;
  logic [10:0] wr_addr_r, wr_addr_nx_s;
  logic [7:0]  wr_data_r, wr_data_nx_s;
  logic [4:0]  row_base_r, row_base_nx_s;
  logic [6:0]  cur_x_r, cur_x_nx_s;
  logic [4:0]  cur_y_r, cur_y_nx_s;
  logic [10:0] clr_cnt_r, clr_cnt_nx_s;
  logic [10:0] clr_addr_r, clr_addr_nx_s;

  logic [5:0]  row_sum_s;
  logic [4:0]  phys_row_s;
  logic [10:0] cur_addr_s;
  logic        printable_s;
  logic        lf_s;

  assign printable_s = (bus.i_char >= 8'h20) && (bus.i_char <= 8'h7E);
  // A line feed is due on an explicit LF or when a printable byte fills the last column.
  assign lf_s = bus.i_valid && (state_r == ST_IDLE) &&
                ((printable_s && (cur_x_r == LAST_COL)) || (bus.i_char == 8'h0A));

  // Cursor physical row: base + y folded back into 0..ROWS-1 with one compare/subtract.
  always_comb begin
    row_sum_s = {1'b0, row_base_r} + {1'b0, cur_y_r};
    if (row_sum_s >= ROWS_W) begin
      phys_row_s = 5'(row_sum_s - ROWS_W);
    end else begin
      phys_row_s = row_sum_s[4:0];
    end
    cur_addr_s = 11'(phys_row_s) * COLS_W + 11'(cur_x_r);
  end

  // Next-state, cursor and write-port decode.
  always_comb begin
    state_nx_s    = state_r;
    wr_nx_s       = 1'b0;
    wr_addr_nx_s  = wr_addr_r;
    wr_data_nx_s  = wr_data_r;
    row_base_nx_s = row_base_r;
    cur_x_nx_s    = cur_x_r;
    cur_y_nx_s    = cur_y_r;
    clr_cnt_nx_s  = clr_cnt_r;
    clr_addr_nx_s = clr_addr_r;
    case (state_r)
      ST_IDLE: begin
        // Scroll re-targets the old top row, which becomes the new bottom row.
        if (lf_s) begin
          if (cur_y_r != LAST_ROW) begin
            cur_y_nx_s = cur_y_r + 5'd1;
          end else begin
            if (row_base_r == LAST_ROW) begin
              row_base_nx_s = 5'd0;
            end else begin
              row_base_nx_s = row_base_r + 5'd1;
            end
            state_nx_s    = ST_CLR_LINE;
            clr_cnt_nx_s  = 11'd0;
            clr_addr_nx_s = 11'(row_base_r) * COLS_W;
          end
        end else begin
          cur_y_nx_s = cur_y_r;
        end
        if (bus.i_valid) begin
          if (printable_s) begin
            wr_nx_s      = 1'b1;
            wr_addr_nx_s = cur_addr_s;
            wr_data_nx_s = bus.i_char;
            if (cur_x_r == LAST_COL) begin
              cur_x_nx_s = 7'd0;
            end else begin
              cur_x_nx_s = cur_x_r + 7'd1;
            end
          end else if (bus.i_char == 8'h0D) begin
            cur_x_nx_s = 7'd0;
          end else if (bus.i_char == 8'h08) begin
            if (cur_x_r != 7'd0) begin
              cur_x_nx_s = cur_x_r - 7'd1;
            end else begin
              cur_x_nx_s = cur_x_r;
            end
          end else if (bus.i_char == 8'h0C) begin
            state_nx_s    = ST_CLR_ALL;
            row_base_nx_s = 5'd0;
            cur_x_nx_s    = 7'd0;
            cur_y_nx_s    = 5'd0;
            clr_cnt_nx_s  = 11'd0;
          end else begin
            cur_x_nx_s = cur_x_r;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CLR_LINE: begin
        wr_nx_s       = 1'b1;
        wr_addr_nx_s  = clr_addr_r;
        wr_data_nx_s  = FILL_CHAR;
        clr_addr_nx_s = clr_addr_r + 11'd1;
        if (clr_cnt_r == LINE_END) begin
          state_nx_s   = ST_IDLE;
          clr_cnt_nx_s = 11'd0;
        end else begin
          clr_cnt_nx_s = clr_cnt_r + 11'd1;
        end
      end
      ST_CLR_ALL: begin
        wr_nx_s      = 1'b1;
        wr_addr_nx_s = clr_cnt_r;
        wr_data_nx_s = FILL_CHAR;
        if (clr_cnt_r == LAST_CELL) begin
          state_nx_s   = ST_IDLE;
          clr_cnt_nx_s = 11'd0;
        end else begin
          clr_cnt_nx_s = clr_cnt_r + 11'd1;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any clear in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= CLEAR_ON_RESET ? ST_CLR_ALL : ST_IDLE;
      wr_r       <= 1'b0;
      wr_addr_r  <= 11'd0;
      wr_data_r  <= 8'd0;
      row_base_r <= 5'd0;
      cur_x_r    <= 7'd0;
      cur_y_r    <= 5'd0;
      clr_cnt_r  <= 11'd0;
      clr_addr_r <= 11'd0;
    end else begin
      state_r    <= state_nx_s;
      wr_r       <= wr_nx_s;
      wr_addr_r  <= wr_addr_nx_s;
      wr_data_r  <= wr_data_nx_s;
      row_base_r <= row_base_nx_s;
      cur_x_r    <= cur_x_nx_s;
      cur_y_r    <= cur_y_nx_s;
      clr_cnt_r  <= clr_cnt_nx_s;
      clr_addr_r <= clr_addr_nx_s;
    end
  end

  assign bus.o_ready     = (state_r == ST_IDLE);
  assign bus.o_wr        = wr_r;
  assign bus.o_wr_addr   = wr_addr_r;
  assign bus.o_wr_data   = wr_data_r;
  assign o_row_base      = row_base_r;
  assign o_cur_x         = cur_x_r;
  assign o_cur_y         = cur_y_r;

endmodule

// File: tb/tb_vt100_term_ctrl.sv
// Self-checking bench for vt100_term_ctrl: directed scenarios plus random byte streams
// compared against a logical-screen model (scroll = shift rows up).
module tb_vt100_term_ctrl;
  localparam int COLS  = 80;
  localparam int ROWS  = 24;
  localparam int TOTAL = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] row_base;
  logic [6:0] cur_x;
  logic [4:0] cur_y;

  vt100_term_ctrl_if bus();

  vt100_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
    .o_row_base(row_base), .o_cur_x(cur_x), .o_cur_y(cur_y)
  );

  always #20 clk = ~clk;

  typedef struct { int addr; int data; int cyc; } wr_t;
  wr_t        wlog[$];
  int         cyc = 0;
  logic [7:0] vram [0:2047];
  bit         oob = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [7:0] m_scr [ROWS][COLS];
  int         m_x, m_y, m_base;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: log every buffer write and mirror it into a shadow screen memory.
  always @(negedge clk) begin
    if (bus.o_wr === 1'b1) begin
      wlog.push_back('{int'(bus.o_wr_addr), int'(bus.o_wr_data), cyc});
      if (int'(bus.o_wr_addr) >= TOTAL) oob <= 1'b1;
      else vram[bus.o_wr_addr] <= bus.o_wr_data;
    end
  end

  // ---------------- reference model ----------------
  task automatic m_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_scr[r][c] = 8'h20;
    m_x = 0; m_y = 0; m_base = 0;
  endtask

  task automatic m_lf();
    if (m_y < ROWS - 1) m_y++;
    else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) m_scr[r][c] = m_scr[r+1][c];
      for (int c = 0; c < COLS; c++) m_scr[ROWS-1][c] = 8'h20;
      m_base = (m_base + 1) % ROWS;
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      m_scr[m_y][m_x] = b;
      if (m_x == COLS - 1) begin m_x = 0; m_lf(); end
      else m_x++;
    end else begin
      case (b)
        8'h0A: m_lf();
        8'h0D: m_x = 0;
        8'h08: if (m_x > 0) m_x--;
        8'h0C: m_clear();
        default: ;
      endcase
    end
  endtask

  function automatic int m_addr();
    return ((m_base + m_y) % ROWS) * COLS + m_x;
  endfunction

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = $urandom_range(0, 99);
    if (r < 70)      b = 8'($urandom_range(32, 126));
    else if (r < 78) b = 8'h0A;
    else if (r < 84) b = 8'h0D;
    else if (r < 90) b = 8'h08;
    else if (r < 94) b = 8'($urandom_range(127, 255));
    else if (r < 99) begin
      b = 8'($urandom_range(0, 31));
      if (b == 8'h0A || b == 8'h0D || b == 8'h08 || b == 8'h0C) b = 8'h1B;
    end else b = 8'h0C;
    return b;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(negedge clk);
    bus.i_char = b; bus.i_valid = 1'b1;
    k = 0;
    while (bus.o_ready !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    if (bus.o_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: o_ready=%b after %0d cycles, required 1", bus.o_ready, k);
    end
    @(posedge clk);
  endtask

  task automatic finish_stream();
    int k;
    @(negedge clk);
    bus.i_valid = 1'b0;
    k = 0;
    while (bus.o_ready !== 1'b1 && k < 5000) begin @(negedge clk); k++; end
    if (bus.o_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: o_ready=%b after %0d cycles, required 1", bus.o_ready, k);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_cursor(input string name);
    n_cmp++;
    if (cur_x !== 7'(m_x)) begin n_bad++; $display("FAIL %s cur_x: got %0d required %0d", name, cur_x, m_x); end
    n_cmp++;
    if (cur_y !== 5'(m_y)) begin n_bad++; $display("FAIL %s cur_y: got %0d required %0d", name, cur_y, m_y); end
    n_cmp++;
    if (row_base !== 5'(m_base)) begin n_bad++; $display("FAIL %s row_base: got %0d required %0d", name, row_base, m_base); end
  endtask

  task automatic check_screen(input string name);
    int nbad, fr, fc, p;
    logic [7:0] got, exp;
    nbad = 0; fr = -1; fc = -1; got = 8'h00; exp = 8'h00;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        p = ((m_base + r) % ROWS) * COLS + c;
        if (vram[p] !== m_scr[r][c]) begin
          if (nbad == 0) begin fr = r; fc = c; got = vram[p]; exp = m_scr[r][c]; end
          nbad++;
        end
      end
    n_cmp++;
    if (nbad != 0) begin
      n_bad++;
      $display("FAIL %s screen: %0d cells differ, first row %0d col %0d got %h required %h", name, nbad, fr, fc, got, exp);
    end
    n_cmp++;
    if (oob !== 1'b0) begin n_bad++; $display("FAIL %s addr_range: write beyond %0d seen", name, TOTAL - 1); end
  endtask

  // Checks log[mk .. mk+n-1] is a consecutive-cycle fill run starting at addr base_a.
  task automatic check_fill_run(input string name, input int mk, input int n, input int base_a);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (mk + i >= wlog.size()) bad++;
      else if (wlog[mk+i].addr != base_a + i || wlog[mk+i].data != 32'h20 ||
               (i > 0 && wlog[mk+i].cyc != wlog[mk+i-1].cyc + 1)) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL %s fill_run: %0d of %0d writes wrong (addr %0d..)", name, bad, n, base_a); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int mk;
    rst_n = 1'b0; bus.i_valid = 1'b0; bus.i_char = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_wr !== 1'b0) begin n_bad++; $display("FAIL reset o_wr: got %b required 0", bus.o_wr); end
    n_cmp++; if (bus.o_wr_addr !== 11'd0) begin n_bad++; $display("FAIL reset o_wr_addr: got %0d required 0", bus.o_wr_addr); end
    n_cmp++; if (bus.o_wr_data !== 8'd0) begin n_bad++; $display("FAIL reset o_wr_data: got %h required 00", bus.o_wr_data); end
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_bad++; $display("FAIL reset o_ready: got %b required 0", bus.o_ready); end
    m_clear();
    check_cursor("reset");
    mk = wlog.size();
    rst_n = 1'b1;
    finish_stream();
    n_cmp++;
    if (wlog.size() - mk != TOTAL) begin n_bad++; $display("FAIL reset clear_count: got %0d required %0d", wlog.size() - mk, TOTAL); end
    check_fill_run("reset", mk, TOTAL, 0);
    check_cursor("reset_done");
    check_screen("reset_done");
  endtask

  task automatic test_back_to_back();
    int mk, ea, eb;
    mk = wlog.size();
    ea = m_addr(); send_byte(8'h41); m_byte(8'h41);
    eb = m_addr(); send_byte(8'h42); m_byte(8'h42);
    finish_stream();
    n_cmp++;
    if (wlog.size() - mk != 2) begin n_bad++; $display("FAIL ab count: got %0d required 2", wlog.size() - mk); end
    else begin
      n_cmp++;
      if (wlog[mk].addr != ea || wlog[mk].data != 32'h41) begin n_bad++; $display("FAIL ab first: got %h@%0d required 41@%0d", wlog[mk].data, wlog[mk].addr, ea); end
      n_cmp++;
      if (wlog[mk+1].addr != eb || wlog[mk+1].data != 32'h42) begin n_bad++; $display("FAIL ab second: got %h@%0d required 42@%0d", wlog[mk+1].data, wlog[mk+1].addr, eb); end
      n_cmp++;
      if (wlog[mk+1].cyc != wlog[mk].cyc + 1) begin n_bad++; $display("FAIL ab spacing: got %0d cycles required 1", wlog[mk+1].cyc - wlog[mk].cyc); end
    end
    check_cursor("ab");
  endtask

  task automatic test_wrap();
    int mk, ea;
    logic [7:0] b;
    send_byte(8'h0D); m_byte(8'h0D);
    repeat (5) begin send_byte(8'h0A); m_byte(8'h0A); end
    repeat (COLS - 1) begin b = 8'($urandom_range(32, 126)); send_byte(b); m_byte(b); end
    finish_stream();
    check_cursor("wrap_pos");
    mk = wlog.size();
    ea = m_addr();
    send_byte(8'h5A); m_byte(8'h5A);
    @(negedge clk);
    bus.i_valid = 1'b0;
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_bad++; $display("FAIL wrap ready: got %b required 1", bus.o_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (wlog.size() - mk != 1) begin n_bad++; $display("FAIL wrap count: got %0d required 1", wlog.size() - mk); end
    else begin
      n_cmp++;
      if (wlog[mk].addr != ea || wlog[mk].data != 32'h5A) begin n_bad++; $display("FAIL wrap write: got %h@%0d required 5a@%0d", wlog[mk].data, wlog[mk].addr, ea); end
    end
    check_cursor("wrap");
    check_screen("wrap");
  endtask

  task automatic test_scroll_lf();
    int mk, old, low;
    while (m_y < ROWS - 1) begin send_byte(8'h0A); m_byte(8'h0A); end
    finish_stream();
    mk = wlog.size();
    old = m_base;
    send_byte(8'h0A); m_byte(8'h0A);
    @(negedge clk);
    bus.i_valid = 1'b0;
    low = 0;
    while (bus.o_ready !== 1'b1 && low < 1000) begin low++; @(negedge clk); end
    @(posedge clk); #1;
    n_cmp++; if (low != COLS) begin n_bad++; $display("FAIL scroll ready_low: got %0d cycles required %0d", low, COLS); end
    n_cmp++; if (wlog.size() - mk != COLS) begin n_bad++; $display("FAIL scroll count: got %0d required %0d", wlog.size() - mk, COLS); end
    check_fill_run("scroll", mk, COLS, old * COLS);
    check_cursor("scroll");
    check_screen("scroll");
  endtask

  task automatic test_base_wrap();
    int mk, old, eq;
    while (m_base != ROWS - 1) begin send_byte(8'h0A); m_byte(8'h0A); end
    finish_stream();
    check_cursor("base_top");
    mk = wlog.size();
    old = m_base;
    send_byte(8'h0D); m_byte(8'h0D);
    send_byte(8'h0A); m_byte(8'h0A);
    eq = m_addr();
    send_byte(8'h51); m_byte(8'h51);
    finish_stream();
    n_cmp++; if (wlog.size() - mk != COLS + 1) begin n_bad++; $display("FAIL basewrap count: got %0d required %0d", wlog.size() - mk, COLS + 1); end
    check_fill_run("basewrap", mk, COLS, old * COLS);
    if (wlog.size() >= mk + COLS + 1) begin
      n_cmp++;
      if (wlog[mk+COLS].addr != eq || wlog[mk+COLS].data != 32'h51) begin
        n_bad++; $display("FAIL basewrap char: got %h@%0d required 51@%0d", wlog[mk+COLS].data, wlog[mk+COLS].addr, eq);
      end
    end
    check_cursor("basewrap");
    check_screen("basewrap");
  endtask

  task automatic test_bs_ff();
    int mk;
    send_byte(8'h0D); m_byte(8'h0D);
    mk = wlog.size();
    send_byte(8'h08); m_byte(8'h08);
    finish_stream();
    n_cmp++; if (wlog.size() != mk) begin n_bad++; $display("FAIL bs0 writes: got %0d required 0", wlog.size() - mk); end
    check_cursor("bs0");
    send_byte(8'h61); m_byte(8'h61);
    send_byte(8'h62); m_byte(8'h62);
    send_byte(8'h08); m_byte(8'h08);
    finish_stream();
    check_cursor("bs1");
    mk = wlog.size();
    send_byte(8'h78); m_byte(8'h78);
    send_byte(8'h0C); m_byte(8'h0C);
    send_byte(8'h79); m_byte(8'h79);
    finish_stream();
    n_cmp++; if (wlog.size() - mk != TOTAL + 2) begin n_bad++; $display("FAIL ff count: got %0d required %0d", wlog.size() - mk, TOTAL + 2); end
    check_fill_run("ff", mk + 1, TOTAL, 0);
    if (wlog.size() >= mk + TOTAL + 2) begin
      n_cmp++;
      if (wlog[mk+TOTAL+1].addr != 0 || wlog[mk+TOTAL+1].data != 32'h79) begin
        n_bad++; $display("FAIL ff after: got %h@%0d required 79@0", wlog[mk+TOTAL+1].data, wlog[mk+TOTAL+1].addr);
      end
    end
    check_cursor("ff");
    check_screen("ff");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 300; i++) begin b = rand_byte(); send_byte(b); m_byte(b); end
      finish_stream();
      check_cursor("random");
      check_screen("random");
    end
  endtask

  task automatic test_reset_abort();
    int mk, k;
    send_byte(8'h0C);
    mk = wlog.size();
    k = 0;
    while (wlog.size() - mk < 500 && k < 5000) begin @(posedge clk); k++; end
    n_cmp++; if (wlog.size() - mk < 500) begin n_bad++; $display("FAIL abort reach500: got %0d writes required 500", wlog.size() - mk); end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_wr !== 1'b0) begin n_bad++; $display("FAIL abort o_wr: got %b required 0", bus.o_wr); end
    mk = wlog.size();
    rst_n = 1'b1;
    finish_stream();
    n_cmp++; if (wlog.size() - mk != TOTAL) begin n_bad++; $display("FAIL abort recount: got %0d required %0d", wlog.size() - mk, TOTAL); end
    check_fill_run("abort", mk, TOTAL, 0);
    m_clear();
    check_cursor("abort");
    check_screen("abort");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_scroll_lf();
    test_base_wrap();
    test_bs_ff();
    test_random();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
